// File: rtl/serial_mag_comparator_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_mag_comparator_if
// Description : Request/result bundle for the bit-serial magnitude comparator.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_mag_comparator_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             a_gt_b;
    logic             a_eq_b;
    logic             a_lt_b;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, a_gt_b, a_eq_b, a_lt_b
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, a_gt_b, a_eq_b, a_lt_b
    );
endinterface
`default_nettype wire

// File: rtl/serial_mag_comparator.sv
`default_nettype none
// ============================================================================
// Module      : serial_mag_comparator
// Description : MSB-first bit-serial magnitude comparator, unsigned or
//               two's-complement, with optional early exit on first difference.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_mag_comparator #(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  wire logic              clk,
    input  wire logic              rst,
    serial_mag_comparator_if.slave bus
);
    localparam int                c_CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST   = c_CNT_W'(WIDTH - 1);
    localparam logic [0:0]        c_IDLE    = 1'b0;
    localparam logic [0:0]        c_COMPARE = 1'b1;

    logic [0:0]         r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_signed;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_decided;
    logic               r_dec_gt;
    logic               r_busy;
    logic               r_done;
    logic               r_gt;
    logic               r_eq;
    logic               r_lt;

    logic w_ai;
    logic w_bi;
    logic w_diff;
    logic w_sign_bit;
    logic w_gt;
    logic w_last;

    // Operands shift left, so the bit under test is always at the MSB.
    assign w_ai       = r_a[WIDTH-1];
    assign w_bi       = r_b[WIDTH-1];
    assign w_diff     = w_ai ^ w_bi;
    assign w_sign_bit = r_signed && (r_cnt == c_LAST);
    // On a differing sign bit, A is greater exactly when B is the negative one.
    assign w_gt       = w_sign_bit ? w_bi : w_ai;
    assign w_last     = (r_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_signed  <= 1'b0;
            r_cnt     <= '0;
            r_decided <= 1'b0;
            r_dec_gt  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_gt      <= 1'b0;
            r_eq      <= 1'b0;
            r_lt      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        r_a       <= bus.a;
                        r_b       <= bus.b;
                        r_signed  <= bus.is_signed;
                        r_cnt     <= c_LAST;
                        r_decided <= 1'b0;
                        r_dec_gt  <= 1'b0;
                        r_busy    <= 1'b1;
                        r_gt      <= 1'b0;
                        r_eq      <= 1'b0;
                        r_lt      <= 1'b0;
                        r_state   <= c_COMPARE;
                    end
                end
                c_COMPARE: begin
                    r_a <= r_a << 1;
                    r_b <= r_b << 1;
                    if ((EARLY_EXIT != 0) && w_diff) begin
                        r_gt    <= w_gt;
                        r_lt    <= ~w_gt;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_IDLE;
                    end else if (w_last) begin
                        if (r_decided) begin
                            r_gt <= r_dec_gt;
                            r_lt <= ~r_dec_gt;
                        end else if (w_diff) begin
                            r_gt <= w_gt;
                            r_lt <= ~w_gt;
                        end else begin
                            r_eq <= 1'b1;
                        end
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                        // Constant-latency mode: only the first difference counts.
                        if (!r_decided && w_diff) begin
                            r_decided <= 1'b1;
                            r_dec_gt  <= w_gt;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.a_gt_b = r_gt;
    assign bus.a_eq_b = r_eq;
    assign bus.a_lt_b = r_lt;
endmodule
`default_nettype wire

// File: doc/serial_mag_comparator.md
Name: serial_mag_comparator

Overview:
Parametrised, bit-serial magnitude comparator; the sequential successor to the 1-bit equality comparator.
- Captures two WIDTH-bit operands on a start pulse and compares them MSB-first, one bit per clock.
- Reports greater/equal/less with a done pulse; supports unsigned and two's-complement operands.
- Optionally exits early on the first differing bit.
- Intended for area-constrained datapaths where a full-width parallel comparator is unwanted.

Parameters:
- WIDTH, 8: operand width in bits; legal range is 1 or more.
- EARLY_EXIT, 1: 1 = finish on the first differing bit; 0 = always examine all WIDTH bits (constant latency).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a comparison; accepted only when busy=0
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while a comparison is in progress
- done  output  1  one-cycle pulse: result valid
- a_gt_b  output  1  registered result A>B
- a_eq_b  output  1  registered result A==B
- a_lt_b  output  1  registered result A<B

Behaviour:
- Reset: rst high forces the following immediately, regardless of clk:
  - state=IDLE; busy=0, done=0, a_gt_b=0, a_eq_b=0, a_lt_b=0
  - shift registers and bit counter cleared
- Reset mid-comparison aborts the operation; no done is produced.
- States: IDLE, COMPARE.
- IDLE:
  - start=1 at edge E0 loads a, b and is_signed into internal registers, sets counter=WIDTH-1 and enters COMPARE.
  - At E0: busy->1, done->0, result flags -> all 0.
- COMPARE, at each edge, examine bit pair (ai, bi) at index counter:
  - ai != bi and (not signed or counter != WIDTH-1): A>B if ai=1 else A<B.
  - ai != bi, signed, counter == WIDTH-1 (sign bit): A>B if ai=0 else A<B (sense inverted).
  - EARLY_EXIT=1 and a difference is found: latch the flag, set done=1, busy=0, return to IDLE.
  - EARLY_EXIT=0: the first difference is held in a sticky decided register; later bits are ignored; the machine always runs WIDTH compare edges.
  - counter==0 with no difference found: a_eq_b=1.
  - Otherwise: counter decrements, stay in COMPARE.
- Latency:
  - EARLY_EXIT=1: the d-th compare edge Ed finishes the operation, where d = index from MSB of the first differing bit (1..WIDTH), or WIDTH if equal.
  - EARLY_EXIT=0: d=WIDTH always.
  - done and the result flags are registered at Ed; done is high for exactly the one cycle following Ed.
- Exactly one of a_gt_b / a_eq_b / a_lt_b is 1 after done.
- Result flags hold until the next accepted start or reset.
- Handshake:
  - start while busy=1 is ignored; the in-flight operation is unaffected.
  - a, b and is_signed changing during COMPARE have no effect (captured copies are used).
  - start in the done cycle (state IDLE) is accepted normally; the flags clear at that edge.
- WIDTH=1:
  - A single compare edge; the only bit is the sign bit.
  - Signed: 1 (= -1) < 0.
- No combinational path from inputs to outputs.

Test Plan:
1. WIDTH=8, EARLY_EXIT=1, unsigned, a=0xA5, b=0xA5, start at E0 -> busy high E0..E8; done high in the cycle after E8; a_eq_b=1, gt=lt=0.
2. Unsigned a=0x80, b=0x7F -> done after E1, a_gt_b=1. Repeat with is_signed=1 -> done after E1, a_lt_b=1.
3. Unsigned a=0x3C, b=0x3D -> differs only at bit 0; done after E8; a_lt_b=1. Signed a=0xFF (-1), b=0xFE (-2) -> done after E8; a_gt_b=1.
4. Start a=0x01, b=0x02; pulse start with a=0xFF, b=0x00 at E3 and change the a/b inputs -> second start ignored, result a_lt_b=1 after E7 (first difference at bit 1). A new start in the done cycle is accepted and flags clear.
5. Assert rst asynchronously mid-COMPARE (between E3 and E4) -> all outputs 0 immediately; no done pulse. A later start compares correctly.
6. EARLY_EXIT=0, a=0x80, b=0x00 -> busy for 8 compare edges; done after E8; a_gt_b=1. Also WIDTH=1, signed, a=1, b=0 -> done after E1; a_lt_b=1.
